// File: rtl/blit_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : blit_engine_pkg
//  Description : Command codes, framebuffer geometry, FSM state encoding and
//                window helpers shared by the blit engine files.
//  Revision    : 1.0  initial release
// ============================================================================
package blit_engine_pkg;

  // Command codes driven by the CPU on blit_op
  localparam logic [2:0] BLIT_OP_CLEAR        = 3'd0;
  localparam logic [2:0] BLIT_OP_SPRITE       = 3'd1;
  localparam logic [2:0] BLIT_OP_SPRITE_16    = 3'd2;
  localparam logic [2:0] BLIT_OP_SCROLL_DOWN  = 3'd3;
  localparam logic [2:0] BLIT_OP_SCROLL_LEFT  = 3'd4;
  localparam logic [2:0] BLIT_OP_SCROLL_RIGHT = 3'd5;

  // Framebuffer geometry: 16 byte columns x 64 rows, 1bpp
  localparam int FB_COLS = 16;
  localparam int FB_ROWS = 64;
  localparam logic [3:0] COL_LAST = 4'(FB_COLS - 1);
  localparam logic [5:0] ROW_LAST = 6'(FB_ROWS - 1);

  // Width of the aligned sprite window (two source bytes plus spill byte)
  localparam int WIN_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_SRC_RD   = 3'd2,
    ST_SRC_WAIT = 3'd3,
    ST_FB_RD    = 3'd4,
    ST_FB_WAIT  = 3'd5,
    ST_FB_WR    = 3'd6
  } state_t;

  // Pick byte column k (0 = leftmost) out of the aligned window
  function automatic logic [7:0] win_byte(input logic [WIN_W-1:0] win,
                                          input logic [1:0]       k);
    logic [7:0] b;
    case (k)
      2'd0:    b = win[23:16];
      2'd1:    b = win[15:8];
      default: b = win[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blit_row_align.sv
`default_nettype none
// ============================================================================
//  Module      : blit_row_align
//  Description : Shifts one sprite row ({hi,lo}) right by the sub-byte X
//                offset into a 24-bit window spanning three byte columns.
//                8-pixel-wide sprites present lo = 0.
//  Revision    : 1.0  initial release
// ============================================================================
module blit_row_align
  import blit_engine_pkg::*;
(
  input  logic [7:0]       i_hi,
  input  logic [7:0]       i_lo,
  input  logic [2:0]       i_shift,
  output logic [WIN_W-1:0] o_win
);

  // MSB is the leftmost pixel, so a larger X moves bits toward the LSB
  assign o_win = {i_hi, i_lo, 8'h00} >> i_shift;

endmodule
`default_nettype wire

// File: rtl/blit_engine.sv
`default_nettype none
// ============================================================================
//  Module      : blit_engine
//  Description : CPU blit responder for the 128x64 1bpp framebuffer. Runs
//                clear, XOR sprite 8xN / 16x16 and 4-pixel / N-row scrolls
//                using one read-modify-write per framebuffer byte.
//  Revision    : 1.0  initial release
// ============================================================================
module blit_engine
  import blit_engine_pkg::*;
#(
  parameter int SCROLL_LR_PX = 4,
  parameter int FB_ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [2:0]           blit_op,
  input  logic [11:0]          blit_src,
  input  logic [3:0]           blit_srcHeight,
  input  logic [6:0]           blit_destX,
  input  logic [5:0]           blit_destY,
  input  logic                 blit_enable,
  output logic                 blit_done,
  output logic                 blit_collision,
  output logic                 src_en,
  output logic [11:0]          src_addr,
  input  logic [7:0]           src_data,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic                 fb_we,
  output logic [7:0]           fb_wdata,
  input  logic [7:0]           fb_rdata
);

  // Left/right scrolls are hard-wired as nibble moves
  if (SCROLL_LR_PX != 4) begin : g_lr_px_unsupported
    $error("blit_engine: SCROLL_LR_PX must be 4");
  end

  state_t      r_state;
  logic        r_en_q;
  logic [2:0]  r_op;
  logic [11:0] r_src;
  logic [3:0]  r_h;
  logic [6:0]  r_dx;
  logic [5:0]  r_dy;
  logic [5:0]  r_row;
  logic [3:0]  r_col;
  logic [3:0]  r_srow;
  logic [1:0]  r_k;
  logic        r_byte;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo;
  logic [3:0]  r_carry;

  logic             w_start;
  logic             w_sprite;
  logic             w_spr16;
  logic [1:0]       w_last_k;
  logic [3:0]       w_last_srow;
  logic [3:0]       w_srow_nx;
  logic [11:0]      w_src_nx;
  logic [WIN_W-1:0] w_win;
  logic [7:0]       w_wbyte;
  logic             w_sd_copy;
  logic [3:0]       w_carry_in;
  logic [7:0]       w_new;
  logic [5:0]       w_nx_row;
  logic [3:0]       w_nx_col;
  logic             w_scroll_last;
  logic [FB_ADDR_W-1:0] w_wr_addr;

  // Byte address read for a given position; scroll-down reads n rows above
  function automatic logic [FB_ADDR_W-1:0] f_rd_addr(
    input logic [2:0] op,   input logic [3:0] n,
    input logic [6:0] dx,   input logic [5:0] dy,
    input logic [5:0] row,  input logic [3:0] col,
    input logic [3:0] srow, input logic [1:0] k);
    logic [5:0] y;
    logic [3:0] c;
    if (op == BLIT_OP_SPRITE || op == BLIT_OP_SPRITE_16) begin
      y = dy + {2'b00, srow};
      c = dx[6:3] + {2'b00, k};
    end else if (op == BLIT_OP_SCROLL_DOWN && row >= {2'b00, n}) begin
      y = row - {2'b00, n};
      c = col;
    end else begin
      y = row;
      c = col;
    end
    return FB_ADDR_W'({y, c});
  endfunction

  assign w_start   = blit_enable & ~r_en_q;
  assign blit_done = (r_state == ST_IDLE) & ~w_start;

  assign w_sprite    = (r_op == BLIT_OP_SPRITE) || (r_op == BLIT_OP_SPRITE_16);
  assign w_spr16     = (r_op == BLIT_OP_SPRITE_16);
  assign w_last_k    = w_spr16 ? 2'd2 : 2'd1;
  assign w_last_srow = w_spr16 ? 4'd15 : (r_h - 4'd1);
  assign w_srow_nx   = r_srow + 4'd1;
  assign w_src_nx    = r_src + (w_spr16 ? {7'd0, w_srow_nx, 1'b0} : {8'd0, w_srow_nx});
  assign w_wbyte     = win_byte(w_win, r_k);
  assign w_sd_copy   = (r_row >= {2'b00, r_h});
  assign w_wr_addr   = (r_op == BLIT_OP_SCROLL_DOWN) ? FB_ADDR_W'({r_row, r_col})
                     : f_rd_addr(r_op, r_h, r_dx, r_dy, r_row, r_col, r_srow, r_k);

  blit_row_align u_align (
    .i_hi    (r_hi),
    .i_lo    (r_lo),
    .i_shift (r_dx[2:0]),
    .o_win   (w_win)
  );

  // New byte value for the byte currently held in fb_rdata
  always_comb begin
    w_carry_in = r_carry;
    if ((r_op == BLIT_OP_SCROLL_RIGHT && r_col == 4'd0) ||
        (r_op == BLIT_OP_SCROLL_LEFT  && r_col == COL_LAST))
      w_carry_in = 4'h0;
    case (r_op)
      BLIT_OP_SPRITE,
      BLIT_OP_SPRITE_16:    w_new = fb_rdata ^ w_wbyte;
      BLIT_OP_SCROLL_DOWN:  w_new = w_sd_copy ? fb_rdata : 8'h00;
      BLIT_OP_SCROLL_RIGHT: w_new = {w_carry_in, fb_rdata[7:4]};
      BLIT_OP_SCROLL_LEFT:  w_new = {fb_rdata[3:0], w_carry_in};
      default:              w_new = 8'h00;
    endcase
  end

  // Next row/column and end-of-pass detect for the three scroll walks
  always_comb begin
    w_nx_row      = r_row;
    w_nx_col      = r_col;
    w_scroll_last = 1'b0;
    case (r_op)
      BLIT_OP_SCROLL_DOWN: begin
        w_scroll_last = (r_row == 6'd0) && (r_col == COL_LAST);
        w_nx_col      = r_col + 4'd1;
        if (r_col == COL_LAST) w_nx_row = r_row - 6'd1;
      end
      BLIT_OP_SCROLL_RIGHT: begin
        w_scroll_last = (r_row == ROW_LAST) && (r_col == COL_LAST);
        w_nx_col      = r_col + 4'd1;
        if (r_col == COL_LAST) w_nx_row = r_row + 6'd1;
      end
      BLIT_OP_SCROLL_LEFT: begin
        w_scroll_last = (r_row == ROW_LAST) && (r_col == 4'd0);
        w_nx_col      = r_col - 4'd1;
        if (r_col == 4'd0) w_nx_row = r_row + 6'd1;
      end
      default: ;
    endcase
  end

  // Command FSM: start latch, source fetch, per-byte RMW and registered outputs
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state        <= ST_IDLE;
      r_en_q         <= 1'b0;
      r_op           <= 3'd0;
      r_src          <= 12'd0;
      r_h            <= 4'd0;
      r_dx           <= 7'd0;
      r_dy           <= 6'd0;
      r_row          <= 6'd0;
      r_col          <= 4'd0;
      r_srow         <= 4'd0;
      r_k            <= 2'd0;
      r_byte         <= 1'b0;
      r_hi           <= 8'h00;
      r_lo           <= 8'h00;
      r_carry        <= 4'h0;
      blit_collision <= 1'b0;
      src_en         <= 1'b0;
      src_addr       <= 12'd0;
      fb_addr        <= '0;
      fb_we          <= 1'b0;
      fb_wdata       <= 8'h00;
    end else begin
      r_en_q <= blit_enable;
      case (r_state)
        ST_IDLE: begin
          fb_we  <= 1'b0;
          src_en <= 1'b0;
          if (w_start) begin
            r_op           <= blit_op;
            r_src          <= blit_src;
            r_h            <= blit_srcHeight;
            r_dx           <= blit_destX;
            r_dy           <= blit_destY;
            r_srow         <= 4'd0;
            r_k            <= 2'd0;
            r_byte         <= 1'b0;
            r_carry        <= 4'h0;
            blit_collision <= 1'b0;
            case (blit_op)
              BLIT_OP_CLEAR: begin
                r_state  <= ST_CLEAR;
                fb_addr  <= '0;
                fb_wdata <= 8'h00;
                fb_we    <= 1'b1;
              end
              BLIT_OP_SPRITE, BLIT_OP_SPRITE_16: begin
                if (blit_op == BLIT_OP_SPRITE_16 || blit_srcHeight != 4'd0) begin
                  r_state  <= ST_SRC_RD;
                  src_en   <= 1'b1;
                  src_addr <= blit_src;
                end
              end
              BLIT_OP_SCROLL_DOWN: begin
                if (blit_srcHeight != 4'd0) begin
                  r_state <= ST_FB_RD;
                  r_row   <= ROW_LAST;
                  r_col   <= 4'd0;
                  fb_addr <= f_rd_addr(blit_op, blit_srcHeight, blit_destX, blit_destY,
                                       ROW_LAST, 4'd0, 4'd0, 2'd0);
                end
              end
              BLIT_OP_SCROLL_RIGHT: begin
                r_state <= ST_FB_RD;
                r_row   <= 6'd0;
                r_col   <= 4'd0;
                fb_addr <= '0;
              end
              BLIT_OP_SCROLL_LEFT: begin
                r_state <= ST_FB_RD;
                r_row   <= 6'd0;
                r_col   <= COL_LAST;
                fb_addr <= FB_ADDR_W'({6'd0, COL_LAST});
              end
              default: ;
            endcase
          end
        end

        ST_CLEAR: begin
          if (fb_addr == '1) begin
            r_state <= ST_IDLE;
            fb_we   <= 1'b0;
          end else begin
            fb_addr <= fb_addr + {{(FB_ADDR_W-1){1'b0}}, 1'b1};
          end
        end

        ST_SRC_RD: r_state <= ST_SRC_WAIT;

        ST_SRC_WAIT: begin
          if (w_spr16 && !r_byte) begin
            r_hi     <= src_data;
            r_byte   <= 1'b1;
            src_addr <= src_addr + 12'd1;
            r_state  <= ST_SRC_RD;
          end else begin
            if (w_spr16) begin
              r_lo <= src_data;
            end else begin
              r_hi <= src_data;
              r_lo <= 8'h00;
            end
            r_byte  <= 1'b0;
            src_en  <= 1'b0;
            r_k     <= 2'd0;
            fb_addr <= f_rd_addr(r_op, r_h, r_dx, r_dy, r_row, r_col, r_srow, 2'd0);
            r_state <= ST_FB_RD;
          end
        end

        ST_FB_RD: r_state <= ST_FB_WAIT;

        ST_FB_WAIT: begin
          fb_we    <= 1'b1;
          fb_wdata <= w_new;
          fb_addr  <= w_wr_addr;
          if (w_sprite && |(fb_rdata & w_wbyte)) blit_collision <= 1'b1;
          if (r_op == BLIT_OP_SCROLL_RIGHT) r_carry <= fb_rdata[3:0];
          if (r_op == BLIT_OP_SCROLL_LEFT)  r_carry <= fb_rdata[7:4];
          r_state  <= ST_FB_WR;
        end

        ST_FB_WR: begin
          fb_we <= 1'b0;
          if (w_sprite) begin
            if (r_k != w_last_k) begin
              r_k     <= r_k + 2'd1;
              fb_addr <= f_rd_addr(r_op, r_h, r_dx, r_dy, r_row, r_col, r_srow, r_k + 2'd1);
              r_state <= ST_FB_RD;
            end else if (r_srow == w_last_srow) begin
              r_state <= ST_IDLE;
            end else begin
              r_srow   <= w_srow_nx;
              r_k      <= 2'd0;
              src_en   <= 1'b1;
              src_addr <= w_src_nx;
              r_state  <= ST_SRC_RD;
            end
          end else if (w_scroll_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_row   <= w_nx_row;
            r_col   <= w_nx_col;
            fb_addr <= f_rd_addr(r_op, r_h, r_dx, r_dy, w_nx_row, w_nx_col, r_srow, r_k);
            r_state <= ST_FB_RD;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
